mcycle_cpu_core: RTL

Parametrised multi-cycle CPU core executing the team's 16-bit instruction set (4-bit opcode, RA, RB, RD fields) on a register file of 16 registers, each DW bits wide. Replaces the fixed 8-bit internal-ROM core with an external instruction-memory handshake, a configurable datapath width, a status-flag register, a defined NOP and a sticky HALT state. It sits between the instruction memory and the debug/observation bus.

---
 rtl/mcycle_cpu_core.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mcycle_cpu_core.sv
// mcycle_cpu_core: multi-cycle core for the 16-bit ISA (op, RA, RB, RD).
// States: IF -> FD -> EX -> RWB -> IF, with HLT ending in an absorbing HALT.
// Build option MCYCLE_CPU_MULDIV_EN includes the multiplier and divider;
// without it opcodes 5 and 6 retire as NOP and raise the sticky illegal flag.
// Fetch handshake: imem_req is held high with a stable imem_addr while in IF
// and go is high; the instruction is taken in the cycle where imem_req and
// imem_ack are both high (imem_data valid in that same cycle). An imem_ack
// with imem_req low is ignored.
module mcycle_cpu_core #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int PC_MAX = 8'h14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_data,
    output logic [AW-1:0] pc_o,
    output logic [2:0]    state_o,
    output logic [3:0]    opcode_o,
    output logic [DW-1:0] wb_data,
    output logic [3:0]    flags,
    output logic          retire,
    output logic          halted,
    output logic          illegal
);
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_FD   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_RWB  = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_ADI  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_DEC  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_NOT  = 4'hC;
    localparam logic [3:0] OP_CMPJ = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [AW-1:0] PC_LAST = AW'(PC_MAX);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, pc_seq;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, w_q, w_d;
    logic [3:0]    flags_q, flags_d;
    logic          illegal_q, illegal_d;
    logic [DW-1:0] regs_q [16];
    logic [DW-1:0] regs_d [16];

    logic [3:0] op, ra, rb, rd;
    assign op = ir_q[15:12];
    assign ra = ir_q[11:8];
    assign rb = ir_q[7:4];
    assign rd = ir_q[3:0];

    // Shared adder for every arithmetic opcode; subtraction is x + ~y + 1 so
    // the carry out reads as "no borrow".
    logic [DW-1:0] add_x, add_y, add_yy, add_res;
    logic [DW:0]   add_full;
    logic          add_sub, add_c, add_v;
    always_comb begin
        add_x   = a_q;
        add_y   = b_q;
        add_sub = 1'b0;
        case (op)
            OP_SUB: add_sub = 1'b1;
            OP_ADI: add_y = DW'(rb);
            OP_DEC: begin add_x = b_q; add_y = DW'(1); add_sub = 1'b1; end
            OP_INC: begin add_x = b_q; add_y = DW'(1); end
            default: ;
        endcase
        add_yy   = add_sub ? ~add_y : add_y;
        add_full = {1'b0, add_x} + {1'b0, add_yy} + {{DW{1'b0}}, add_sub};
        add_res  = add_full[DW-1:0];
        add_c    = add_full[DW];
        add_v    = (add_x[DW-1] == add_yy[DW-1]) && (add_res[DW-1] != add_x[DW-1]);
    end

    // EX result and its class (arith / logic / disabled-by-build).
    logic [DW-1:0] ex_res;
    logic          ex_arith, ex_logic, ex_bad, writes;
    always_comb begin
        ex_res   = w_q;
        ex_arith = 1'b0;
        ex_logic = 1'b0;
        ex_bad   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADI, OP_DEC, OP_INC: begin
                ex_res   = add_res;
                ex_arith = 1'b1;
            end
            OP_LDI:  ex_res = DW'({ra, rb});
`ifdef MCYCLE_CPU_MULDIV_EN
            OP_DIV:  begin ex_res = (b_q == '0) ? '1 : a_q / b_q; ex_logic = 1'b1; end
            OP_MUL:  begin ex_res = a_q * b_q; ex_logic = 1'b1; end
`else
            OP_DIV, OP_MUL: ex_bad = 1'b1;
`endif
            OP_NOR:  begin ex_res = ~(a_q | b_q); ex_logic = 1'b1; end
            OP_NAND: begin ex_res = ~(a_q & b_q); ex_logic = 1'b1; end
            OP_XOR:  begin ex_res = a_q ^ b_q;    ex_logic = 1'b1; end
            OP_NOT:  begin ex_res = ~b_q;         ex_logic = 1'b1; end
            default: ;
        endcase
        writes = ex_arith | ex_logic | (op == OP_LDI);
    end

    assign pc_seq   = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    assign imem_req = (state_q == S_IF) && go && !reset;

    // Next-state, datapath latches and register-file writeback.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        w_d       = w_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        regs_d    = regs_q;
        case (state_q)
            S_IF: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_FD;
                end
            end
            S_FD: begin
                a_d     = regs_q[ra];
                b_d     = regs_q[rb];
                state_d = S_EX;
            end
            S_EX: begin
                w_d = ex_res;
                if (ex_arith) begin
                    flags_d = {add_c, add_v, (ex_res == '0), ex_res[DW-1]};
                end else if (ex_logic) begin
                    flags_d = {2'b00, (ex_res == '0), ex_res[DW-1]};
                end
                if (ex_bad) illegal_d = 1'b1;
                state_d = S_RWB;
            end
            S_RWB: begin
                if (writes) regs_d[rd] = w_q;
                case (op)
                    OP_CMPJ: pc_d = (a_q >= b_q) ? pc_q + AW'(rd) : pc_seq;
                    OP_JMP:  pc_d = AW'({ra, rb});
                    OP_HLT:  pc_d = pc_q;
                    default: pc_d = pc_seq;
                endcase
                state_d = (op == OP_HLT) ? S_HALT : S_IF;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Control and datapath flops; reset aborts any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            w_q       <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            w_q       <= w_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc_o      = pc_q;
    assign state_o   = state_q;
    assign opcode_o  = op;
    assign wb_data   = w_q;
    assign flags     = flags_q;
    assign retire    = (state_q == S_RWB);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
endmodule
